// File: rtl/mmio_peripherals_pkg.sv
// Shared constants for the memory-mapped peripheral block: register offsets,
// TCON bit positions and the active-low seven-segment glyph table.
package mmio_peripherals_pkg;

  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_LED     = 32'h0000_000C;
  localparam logic [31:0] OFF_DIGITS  = 32'h0000_0010;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IRQ = 2;

  // Segment a is bit 0, g is bit 6; a cleared bit lights the segment.
  localparam logic [6:0] GLYPHS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/mmio_peripherals_if.sv
// MEM-stage bus as seen by the peripheral block: strobes, address and store
// data from the core, combinational read data and hit flag back to it.
interface mmio_peripherals_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic        Device_Hit;

  modport master (
    output MemRead,
    output MemWrite,
    output MemBus_Address,
    output MemBus_Write_Data,
    input  Device_Read_Data,
    input  Device_Hit
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  MemBus_Address,
    input  MemBus_Write_Data,
    output Device_Read_Data,
    output Device_Hit
  );

endinterface

// File: rtl/mmio_peripherals_hex_to_seg.sv
// Combinational 4-bit hex value to active-low seven-segment pattern.
module hex_to_seg
  import mmio_peripherals_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPHS[hex];

endmodule

// File: rtl/mmio_peripherals.sv
// Timer with auto-reload and interrupt, free-running systick, LED register and
// a four-digit multiplexed seven-segment driver behind one register window.
module mmio_peripherals
  import mmio_peripherals_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          SCAN_DIV  = 100000
) (
  input  logic                clk,
  input  logic                reset,
  mmio_peripherals_if.slave   bus,
  output logic                irq,
  output logic [7:0]          leds,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [31:0]   th;
  logic [31:0]   tl;
  logic [2:0]    tcon;
  logic [7:0]    led_reg;
  logic [15:0]   digits;
  logic [31:0]   systick;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;

  logic sel_th;
  logic sel_tl;
  logic sel_tcon;
  logic sel_led;
  logic sel_digits;
  logic sel_systick;

  logic wr_th;
  logic wr_tl;
  logic wr_tcon;
  logic wr_led;
  logic wr_digits;

  logic        tl_max;
  logic        irq_set;
  logic [31:0] rdata;
  logic [3:0]  nibble;
  logic [31:0] wdata;

  assign wdata = bus.MemBus_Write_Data;

  // Exact 32-bit match only, so misaligned byte addresses never alias a register.
  assign sel_th      = (bus.MemBus_Address == BASE_ADDR + OFF_TH);
  assign sel_tl      = (bus.MemBus_Address == BASE_ADDR + OFF_TL);
  assign sel_tcon    = (bus.MemBus_Address == BASE_ADDR + OFF_TCON);
  assign sel_led     = (bus.MemBus_Address == BASE_ADDR + OFF_LED);
  assign sel_digits  = (bus.MemBus_Address == BASE_ADDR + OFF_DIGITS);
  assign sel_systick = (bus.MemBus_Address == BASE_ADDR + OFF_SYSTICK);

  assign bus.Device_Hit = sel_th | sel_tl | sel_tcon | sel_led | sel_digits | sel_systick;

  assign wr_th     = bus.MemWrite & sel_th;
  assign wr_tl     = bus.MemWrite & sel_tl;
  assign wr_tcon   = bus.MemWrite & sel_tcon;
  assign wr_led    = bus.MemWrite & sel_led;
  assign wr_digits = bus.MemWrite & sel_digits;

  always_comb begin
    rdata = 32'h0;
    if (sel_th)      rdata = th;
    if (sel_tl)      rdata = tl;
    if (sel_tcon)    rdata = {29'h0, tcon};
    if (sel_led)     rdata = {24'h0, led_reg};
    if (sel_digits)  rdata = {16'h0, digits};
    if (sel_systick) rdata = systick;
  end

  assign bus.Device_Read_Data = bus.MemRead ? rdata : 32'h0;

  // A software write to TL in the overflow cycle cancels that overflow entirely.
  assign tl_max  = (tl == 32'hFFFF_FFFF);
  assign irq_set = tcon[TCON_EN] & tcon[TCON_IE] & tl_max & ~wr_tl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= 32'h0;
      tl <= 32'h0;
    end else begin
      if (wr_th)
        th <= wdata;
      if (wr_tl)
        tl <= wdata;
      else if (tcon[TCON_EN])
        tl <= tl_max ? th : tl + 32'd1;
    end
  end

  // The hardware status set is ORed in after the write so it cannot be lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= 3'b000;
    end else if (wr_tcon) begin
      tcon <= {wdata[TCON_IRQ] | irq_set, wdata[TCON_IE], wdata[TCON_EN]};
    end else if (irq_set) begin
      tcon[TCON_IRQ] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg <= 8'h00;
      digits  <= 16'h0000;
      systick <= 32'h0;
    end else begin
      if (wr_led)
        led_reg <= wdata[7:0];
      if (wr_digits)
        digits <= wdata[15:0];
      systick <= systick + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  always_comb begin
    nibble = digits[3:0];
    case (digit_idx)
      2'd0: nibble = digits[3:0];
      2'd1: nibble = digits[7:4];
      2'd2: nibble = digits[11:8];
      2'd3: nibble = digits[15:12];
      default: nibble = digits[3:0];
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (seg)
  );

  assign an   = ~(4'b0001 << digit_idx);
  assign irq  = tcon[TCON_IRQ];
  assign leds = led_reg;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Scoreboard bench for mmio_peripherals: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_mmio_peripherals;

  localparam logic [31:0] BASE         = 32'h4000_0000;
  localparam logic [31:0] ADDR_TH      = BASE + 32'h00;
  localparam logic [31:0] ADDR_TL      = BASE + 32'h04;
  localparam logic [31:0] ADDR_TCON    = BASE + 32'h08;
  localparam logic [31:0] ADDR_LED     = BASE + 32'h0C;
  localparam logic [31:0] ADDR_DIGITS  = BASE + 32'h10;
  localparam logic [31:0] ADDR_SYSTICK = BASE + 32'h14;
  localparam int          SCAN         = 4;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq;
  logic [7:0]  leds;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [31:0] tbTicks;
  logic [31:0] regAddrs [6];
  logic [6:0]  glyphRef [16];
  expect_t     expectQ [$];
  int          checkCount = 0;
  int          errorCount = 0;

  mmio_peripherals_if bus ();

  mmio_peripherals #(
    .BASE_ADDR (BASE),
    .SCAN_DIV  (SCAN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq),
    .leds  (leds),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // Edges seen since the last reset release drive both the systick and scan models.
  always @(posedge clk or negedge reset) begin
    if (!reset) tbTicks <= 32'd0;
    else        tbTicks <= tbTicks + 32'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    expectQ.push_back(e);
  endtask

  task automatic popCompare(input logic [31:0] observed);
    expect_t e;
    if (expectQ.size() == 0) begin
      checkOutput("scoreboard_underflow", 32'(expectQ.size()), 32'd1);
    end else begin
      e = expectQ.pop_front();
      checkOutput(e.tag, observed, e.value);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.MemWrite          = 1'b1;
    bus.MemBus_Address    = addr;
    bus.MemBus_Write_Data = data;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic readAndCheck(input string tag, input logic [31:0] addr,
                              input logic [31:0] expData, input logic expHit);
    pushExpect({tag, "_data"}, expData);
    pushExpect({tag, "_hit"}, {31'h0, expHit});
    bus.MemBus_Address = addr;
    bus.MemRead        = 1'b1;
    #1;
    popCompare(bus.Device_Read_Data);
    popCompare({31'h0, bus.Device_Hit});
    bus.MemRead = 1'b0;
  endtask

  task automatic checkPins(input string tag, input logic [3:0] expAn, input logic [6:0] expSeg,
                           input logic expIrq, input logic [7:0] expLeds);
    pushExpect({tag, "_an"}, {28'h0, expAn});
    pushExpect({tag, "_seg"}, {25'h0, expSeg});
    pushExpect({tag, "_irq"}, {31'h0, expIrq});
    pushExpect({tag, "_leds"}, {24'h0, expLeds});
    popCompare({28'h0, an});
    popCompare({25'h0, seg});
    popCompare({31'h0, irq});
    popCompare({24'h0, leds});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  idx;
    logic [15:0] digitsVal;
    logic [3:0]  nib;

    regAddrs = '{ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_DIGITS, ADDR_SYSTICK};
    glyphRef = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    bus.MemRead           = 1'b0;
    bus.MemWrite          = 1'b1;
    bus.MemBus_Address    = ADDR_LED;
    bus.MemBus_Write_Data = 32'hFFFF_FFFF;

    // Reset held with a write strobe active must leave everything cleared.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) readAndCheck("reset_read", regAddrs[i], 32'h0, 1'b1);
    checkPins("reset_pins", 4'b1110, 7'b1000000, 1'b0, 8'h00);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    reset        = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    readAndCheck("systick_5", ADDR_SYSTICK, 32'd5, 1'b1);

    // Reload and interrupt.
    applyStimulus(ADDR_TH, 32'hFFFF_FFFC);
    applyStimulus(ADDR_TL, 32'hFFFF_FFFE);
    applyStimulus(ADDR_TCON, 32'h3);
    readAndCheck("tl_armed", ADDR_TL, 32'hFFFF_FFFE, 1'b1);
    tick();
    readAndCheck("tl_max", ADDR_TL, 32'hFFFF_FFFF, 1'b1);
    checkOutput("irq_before", {31'h0, irq}, 32'd0);
    tick();
    readAndCheck("tl_reload", ADDR_TL, 32'hFFFF_FFFC, 1'b1);
    checkOutput("irq_set", {31'h0, irq}, 32'd1);
    readAndCheck("tcon_status", ADDR_TCON, 32'h7, 1'b1);
    applyStimulus(ADDR_TCON, 32'h3);
    checkOutput("irq_cleared", {31'h0, irq}, 32'd0);

    // Software clear in the overflow cycle loses to the hardware set.
    applyStimulus(ADDR_TCON, 32'h0);
    applyStimulus(ADDR_TL, 32'hFFFF_FFFE);
    applyStimulus(ADDR_TCON, 32'h3);
    tick();
    readAndCheck("tl_max2", ADDR_TL, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(ADDR_TCON, 32'h3);
    readAndCheck("tcon_hw_wins", ADDR_TCON, 32'h7, 1'b1);
    readAndCheck("tl_reload2", ADDR_TL, 32'hFFFF_FFFC, 1'b1);

    // TL write in the overflow cycle suppresses reload and interrupt.
    applyStimulus(ADDR_TCON, 32'h0);
    checkOutput("irq_sw_clear", {31'h0, irq}, 32'd0);
    applyStimulus(ADDR_TL, 32'hFFFF_FFFE);
    applyStimulus(ADDR_TCON, 32'h3);
    tick();
    readAndCheck("tl_max3", ADDR_TL, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(ADDR_TL, 32'h10);
    readAndCheck("tl_write_wins", ADDR_TL, 32'h10, 1'b1);
    checkOutput("irq_suppressed", {31'h0, irq}, 32'd0);
    readAndCheck("tcon_no_status", ADDR_TCON, 32'h3, 1'b1);
    applyStimulus(ADDR_TCON, 32'h0);
    tick();
    readAndCheck("tl_hold", ADDR_TL, 32'h11, 1'b1);
    readAndCheck("th_kept", ADDR_TH, 32'hFFFF_FFFC, 1'b1);

    // Decode edges.
    tick();
    readAndCheck("unmapped_18", BASE + 32'h18, 32'h0, 1'b0);
    readAndCheck("misaligned_02", BASE + 32'h02, 32'h0, 1'b0);
    pushExpect("noread_data", 32'h0);
    bus.MemBus_Address = ADDR_TH;
    bus.MemRead        = 1'b0;
    #1;
    popCompare(bus.Device_Read_Data);
    applyStimulus(ADDR_SYSTICK, 32'h0);
    readAndCheck("systick_wr_ignored", ADDR_SYSTICK, tbTicks, 1'b1);
    tick();
    readAndCheck("systick_counting", ADDR_SYSTICK, tbTicks, 1'b1);
    applyStimulus(ADDR_LED, 32'h1A5);
    checkOutput("leds_pin", {24'h0, leds}, 32'hA5);
    readAndCheck("led_read", ADDR_LED, 32'hA5, 1'b1);

    // Display scan against a model derived from edges since reset.
    digitsVal = 16'h12AF;
    applyStimulus(ADDR_DIGITS, {16'h0, digitsVal});
    readAndCheck("digits_read", ADDR_DIGITS, 32'h12AF, 1'b1);
    for (int c = 0; c < 24; c++) begin
      idx = 2'((tbTicks / SCAN) % 4);
      nib = 4'((digitsVal >> (4 * idx)) & 16'hF);
      pushExpect("scan_an", {28'h0, ~(4'b0001 << idx)});
      pushExpect("scan_seg", {25'h0, glyphRef[nib]});
      popCompare({28'h0, an});
      popCompare({25'h0, seg});
      tick();
    end

    // Reset in the middle of counting and scanning.
    applyStimulus(ADDR_TCON, 32'h3);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkPins("midreset_pins", 4'b1110, 7'b1000000, 1'b0, 8'h00);
    readAndCheck("midreset_tl", ADDR_TL, 32'h0, 1'b1);
    readAndCheck("midreset_tcon", ADDR_TCON, 32'h0, 1'b1);
    readAndCheck("midreset_systick", ADDR_SYSTICK, 32'h0, 1'b1);
    readAndCheck("midreset_digits", ADDR_DIGITS, 32'h0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    readAndCheck("post_reset_systick", ADDR_SYSTICK, 32'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
